// File: rtl/booth_mult_32_pkg.sv
// booth_mult_32_pkg
//   Shared definitions for the radix-2 Booth multiplier: the FSM state
//   encoding, the operand width, the number of Booth steps, and the width of
//   the step counter.
package booth_mult_32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEPS = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult_32_cla.sv
// cla_32
//   32-bit adder made of four 8-bit carry-lookahead blocks. Each block
//   produces a group generate/propagate pair, and a second lookahead level
//   derives the block carry-ins from those pairs.
//   Ports:
//     sum  [31:0] out  A + B + cin (low 32 bits)
//     cout        out  carry out of bit 31
//     A    [31:0] in   first addend
//     B    [31:0] in   second addend
//     cin         in   carry in
module cla_32 (
    output logic [31:0] sum,
    output logic        cout,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin
);

    logic [31:0] g;
    logic [31:0] p;
    logic [3:0]  bg;
    logic [3:0]  bp;
    logic [4:0]  bc;

    assign g = A & B;
    assign p = A ^ B;

    // Group generate/propagate for each 8-bit block.
    always_comb begin
        logic gk;
        logic pk;
        bg = '0;
        bp = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gk = 1'b0;
            pk = 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
                gk = g[8*k+i] | (p[8*k+i] & gk);
                pk = pk & p[8*k+i];
            end
            bg[k] = gk;
            bp[k] = pk;
        end
    end

    // Second-level lookahead: block carry-ins straight from group terms.
    assign bc[0] = cin;
    assign bc[1] = bg[0] | (bp[0] & cin);
    assign bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
    assign bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                 | (bp[2] & bp[1] & bp[0] & cin);
    assign bc[4] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                 | (bp[3] & bp[2] & bp[1] & bg[0])
                 | (bp[3] & bp[2] & bp[1] & bp[0] & cin);

    assign cout = bc[4];

    always_comb begin
        logic c;
        sum = '0;
        c   = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            c = bc[k];
            for (int unsigned i = 0; i < 8; i++) begin
                sum[8*k+i] = p[8*k+i] ^ c;
                c = g[8*k+i] | (p[8*k+i] & c);
            end
        end
    end

endmodule

// File: rtl/booth_mult_32.sv
// booth_mult_32
//   Sequential radix-2 Booth multiplier. A start pulse loads the operands.
//   The multiplier then performs 32 add/subtract-and-shift steps on a 65-bit
//   {HI, LO, q} register. On the following edge it latches the low product
//   word and the overflow flag, and it pulses data_resultRDY for one cycle.
//   Ports:
//     clock                 in   rising-edge clock
//     reset_n               in   asynchronous active-low reset
//     ctrl_MULT             in   start pulse (ignored while busy)
//     data_operandA  [31:0] in   signed multiplicand
//     data_operandB  [31:0] in   signed multiplier
//     data_result    [31:0] out  low 32 bits of the product, held
//     data_exception        out  product does not fit in 32-bit signed
//     data_resultRDY        out  one-cycle valid pulse (DONE state)
//     busy                  out  high while the RUN state is active
module booth_mult_32 #(
    parameter int unsigned WIDTH = booth_mult_32_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    import booth_mult_32_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             q;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;

    logic             do_add;
    logic             do_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             unused_cout;
    logic [WIDTH-1:0] acc;
    logic             acc_sign;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    // {LO[0], q}: 01 -> add M, 10 -> subtract M, 00/11 -> no change.
    assign do_add = lo[0] ^ q;
    assign do_sub = lo[0] & ~q;
    assign add_b  = do_sub ? ~m : m;

    cla_32 u_cla (
        .sum  (sum),
        .cout (unused_cout),
        .A    (hi),
        .B    (add_b),
        .cin  (do_sub)
    );

    // The 32-bit sum can overflow (for example, 0 - 0x80000000). The bit
    // shifted into HI[31] must be the sign of the true 33-bit sum, so it is
    // the result sign corrected by the signed-overflow condition.
    always_comb begin
        acc      = hi;
        acc_sign = hi[WIDTH-1];
        if (do_add) begin
            acc = sum;
            if ((hi[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != hi[WIDTH-1]))
                acc_sign = ~sum[WIDTH-1];
            else
                acc_sign = sum[WIDTH-1];
        end
        hi_next = {acc_sign, acc[WIDTH-1:1]};
        lo_next = {acc[0], lo[WIDTH-1:1]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            hi             <= '0;
            lo             <= '0;
            q              <= 1'b0;
            m              <= '0;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ctrl_MULT) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        hi    <= '0;
                        lo    <= data_operandB;
                        q     <= 1'b0;
                        m     <= data_operandA;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // After the last Booth step, one more edge latches the
                    // result and enters DONE.
                    if (cnt == CNT_W'(STEPS)) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= lo;
                        data_exception <= (hi != {WIDTH{lo[WIDTH-1]}});
                    end else begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        q   <= lo[0];
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_32.sv
// tb_booth_mult_32
//   Self-checking bench for booth_mult_32. It applies vectors from a table and
//   from random operands, plus hand-written sequences for a restart attempt
//   during RUN, reset during RUN, and a back-to-back start in DONE. Expected
//   results go into a queue at each start. A negedge monitor pops the queue
//   at every data_resultRDY pulse and checks the value, the exception flag
//   and the cycle of arrival.
module tb_booth_mult_32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    always #5 clock = ~clock;

    booth_mult_32 #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Full-width signed product: gives the low word and the fit-in-32 flag.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        logic signed [63:0] sa;
        logic signed [63:0] sb64;
        logic signed [63:0] p;
        sa   = $signed(a);
        sb64 = $signed(b);
        p    = sa * sb64;
        res  = p[31:0];
        exc  = (p[63:32] != {32{p[31]}});
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1 && data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {32'd0, data_result}, {32'd0, e.res});
                check("exception", {63'd0, data_exception}, {63'd0, e.exc});
                check("rdy_cycle", {32'd0, cyc}, {32'd0, e.due});
                check("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Called at a negedge; the following posedge is the start edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input bit push);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        if (push) begin
            e.res = res;
            e.exc = exc;
            e.due = cyc + 34;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        if (push) check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_result"}, {32'd0, data_result}, 64'd0);
        check({tag, "_exception"}, {63'd0, data_exception}, 64'd0);
        check({tag, "_rdy"}, {63'd0, data_resultRDY}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[12];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rres;
        logic        rexc;
        int unsigned due;
        int          guard;

        tbl[0]  = '{32'd3,          32'd4,          32'h0000000C, 1'b0};
        tbl[1]  = '{32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0};
        tbl[2]  = '{32'hFFFFFFFB,   32'hFFFFFFFB,   32'h00000019, 1'b0};
        tbl[3]  = '{32'h00010000,   32'h00010000,   32'h00000000, 1'b1};
        tbl[4]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1};
        tbl[5]  = '{32'h7FFFFFFF,   32'h7FFFFFFF,   32'h00000001, 1'b1};
        tbl[6]  = '{32'h80000000,   32'h80000000,   32'h00000000, 1'b1};
        tbl[7]  = '{32'h80000000,   32'h00000001,   32'h80000000, 1'b0};
        tbl[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0};
        tbl[9]  = '{32'h00003039,   32'hFFFFFFFF,   32'hFFFFCFC7, 1'b0};
        tbl[10] = '{32'h00008000,   32'h00010000,   32'h80000000, 1'b1};
        tbl[11] = '{32'hFFFF8000,   32'h00010000,   32'h80000000, 1'b0};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Table vectors, one at a time.
        for (int i = 0; i < 12; i++) begin
            start(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc, 1'b1);
            wait_drain(60);
            @(negedge clock);
            check("busy_idle", {63'd0, busy}, 64'd0);
        end

        // Random operands against the full-width model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? ($urandom & 32'h0000FFFF) : $urandom;
            model(ra, rb, rres, rexc);
            start(ra, rb, rres, rexc, 1'b1);
            wait_drain(60);
        end

        // A start pulse during RUN is ignored: one result, original timing.
        @(negedge clock);
        start(32'd2, 32'd3, 32'd6, 1'b0, 1'b1);
        repeat (8) @(negedge clock);
        start(32'd9, 32'd9, 32'd81, 1'b0, 1'b0);
        check("busy_ignored_start", {63'd0, busy}, 64'd1);
        wait_drain(60);
        repeat (45) @(negedge clock);
        check("held_result", {32'd0, data_result}, 64'd6);
        check("busy_after_ignored", {63'd0, busy}, 64'd0);

        // Reset during RUN: outputs clear at once and no pulse follows.
        start(32'd5, 32'd5, 32'd25, 1'b0, 1'b1);
        repeat (13) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        sb.delete();
        #1 check_zero_outputs("async_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        start(32'd7, 32'd8, 32'd56, 1'b0, 1'b1);
        wait_drain(60);
        repeat (40) @(negedge clock);

        // Back-to-back: new start accepted in the DONE cycle.
        start(32'hFFFFFFFD, 32'd11, 32'hFFFFFFDF, 1'b0, 1'b1);
        due   = sb[0].due;
        guard = 0;
        while (cyc != due && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("b2b_rdy_visible", {63'd0, data_resultRDY}, 64'd1);
        start(32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 1'b1);
        wait_drain(80);
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mult_32.md
BOOTH_MULT_32 -- requirements
Module: booth_mult_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ctrl_MULT  input  1  start pulse; operands are sampled on the same edge.
REQ-005 SHALL have port data_operandA  input  32  signed multiplicand.
REQ-006 SHALL have port data_operandB  input  32  signed multiplier.
REQ-007 SHALL have port data_result  output  32  low 32 bits of the signed product.
REQ-008 SHALL have port data_exception  output  1  product does not fit in 32-bit signed.
REQ-009 SHALL have port data_resultRDY  output  1  one-cycle pulse marking data_result/data_exception valid.
REQ-010 SHALL have port busy  output  1  high while RUN is active.

Function
REQ-011 SHALL implement radix-2 Booth multiplication using a 65-bit product register {HI[31:0], LO[31:0], q}.
- HI is the accumulator, LO holds the multiplier, q is the extra low bit.
REQ-012 SHALL use FSM states IDLE, RUN and DONE.
- IDLE --ctrl_MULT--> RUN.
- RUN --step 31 complete--> DONE.
- DONE --> IDLE, or DONE --ctrl_MULT--> RUN.
REQ-013 On an accepted start, SHALL load HI=0, LO=data_operandB, q=0, M=data_operandA, and step counter=0.
REQ-014 Each RUN edge SHALL perform one step, selected by {LO[0],q}:
- 01: HI=HI+M.
- 10: HI=HI-M.
- 00/11: HI unchanged.
- Then arithmetic-shift the 65-bit register right by 1 and increment the counter.
REQ-015 Subtraction SHALL be HI + ~M with carry-in 1 through the shared adder; carry-out SHALL be discarded.
REQ-016 SHALL perform exactly 32 steps.
- data_resultRDY is high during the single cycle following the 33rd rising edge after the start edge.
REQ-017 SHALL set data_result = LO in DONE, and hold it until the next accepted start.
REQ-018 SHALL set data_exception=1 iff HI differs from 32 copies of LO[31]; it is valid and held alongside data_result.
REQ-019 SHALL ignore ctrl_MULT while in RUN; operands, counter and outputs SHALL be unaffected.
REQ-020 SHALL accept ctrl_MULT in DONE: RDY pulses that cycle and RUN begins on the same edge.
REQ-021 busy SHALL be 1 exactly in RUN; data_resultRDY SHALL be 1 exactly in DONE.
REQ-022 Operand changes after the start edge SHALL have no effect.

Reset
REQ-023 reset_n low SHALL immediately force the following, regardless of clock:
- state=IDLE.
- product register, M and counter = 0.
- data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no data_resultRDY pulse for it ever occurs.
REQ-025 After reset_n deasserts, the first start SHALL be accepted on the first rising edge with ctrl_MULT=1.

Structure
REQ-026 The shared package SHALL hold:
- the state encoding (IDLE/RUN/DONE);
- WIDTH=32;
- step count 32;
- counter width 6.
REQ-027 SHALL instantiate exactly one sub-module, cla_32: a 32-bit adder built from four 8-bit carry-lookahead blocks with block generate/propagate.
- Ports: sum, cout, A, B, cin.
- It is the only arithmetic in the datapath.
REQ-028 The datapath SHALL be a single 65-bit register plus a 32-bit M register; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-029 A=3, B=4, start pulse -> data_resultRDY on the 33rd post-start cycle, result=0x0000000C, exception=0.
REQ-030 A=-7, B=6 -> result=0xFFFFFFD6, exception=0; A=-5, B=-5 -> result=0x00000019, exception=0.
REQ-031 A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1; A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
REQ-032 Start 2*3, then at cycle 10 pulse ctrl_MULT with 9*9 -> result=6 at the original timing, and no second RDY.
REQ-033 Start 5*5, assert reset_n=0 at cycle 15 for 2 cycles -> all outputs 0 immediately, and no RDY.
- Then start 7*8 -> result=56 after 33 cycles.
REQ-034 Back-to-back: ctrl_MULT held high during the DONE cycle with new operands 0x7FFFFFFF*2 -> the first result is observed.
- The second result, 0xFFFFFFFE with exception=1, is ready 33 cycles later.
